// File: rtl/envelope_generator.sv
// ADSR envelope generator driven by a gate, applied as a gain to a signed sample stream.
// Envelope updates every sample_clock edge; out_sample lags sample_in by one cycle.
module envelope_generator #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int ENV_WIDTH    = 16
) (
   input  logic                    sample_clock,
   input  logic                    rst,
   input  logic                    gate,
   input  logic [ENV_WIDTH-1:0]    attack_step,
   input  logic [ENV_WIDTH-1:0]    decay_step,
   input  logic [ENV_WIDTH-1:0]    sustain_level,
   input  logic [ENV_WIDTH-1:0]    release_step,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   output logic [SAMPLE_WIDTH-1:0] out_sample,
   output logic [ENV_WIDTH-1:0]    env_level,
   output logic [2:0]              env_state,
   output logic                    active
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;

   localparam logic [ENV_WIDTH-1:0] LEVEL_MAX = '1;
   localparam int PROD_WIDTH = SAMPLE_WIDTH + ENV_WIDTH + 1;

   state_t                  state;
   state_t                  state_next;
   logic [ENV_WIDTH-1:0]    level_next;
   logic                    gate_q;
   logic                    rise;
   logic                    fall;
   logic                    attack_sat;
   logic                    decay_done;
   logic                    release_done;
   logic [ENV_WIDTH:0]      decay_floor;
   logic [PROD_WIDTH-1:0]   sample_ext;
   logic [PROD_WIDTH-1:0]   env_ext;
   logic [PROD_WIDTH-1:0]   product;
   logic                    unused_product_bits;

   assign rise = gate & ~gate_q;
   assign fall = ~gate & gate_q;

   // All end-of-segment tests are arranged so no operand can overflow.
   assign attack_sat   = (attack_step == '0) || (env_level >= (LEVEL_MAX - attack_step));
   assign decay_floor  = {1'b0, sustain_level} + {1'b0, decay_step};
   assign decay_done   = (decay_step == '0) || ({1'b0, env_level} <= decay_floor);
   assign release_done = (release_step == '0) || (env_level <= release_step);

   always_comb begin
      state_next = state;
      level_next = env_level;
      if (rise) begin
         if (attack_sat) begin
            level_next = LEVEL_MAX;
            state_next = DECAY;
         end else begin
            level_next = env_level + attack_step;
            state_next = ATTACK;
         end
      end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
         if (release_done) begin
            level_next = '0;
            state_next = IDLE;
         end else begin
            level_next = env_level - release_step;
            state_next = RELEASE;
         end
      end else begin
         case (state)
            IDLE: begin
               level_next = '0;
            end
            ATTACK: begin
               if (attack_sat) begin
                  level_next = LEVEL_MAX;
                  state_next = DECAY;
               end else begin
                  level_next = env_level + attack_step;
               end
            end
            DECAY: begin
               // Also catches sustain_level being raised above the current level.
               if (decay_done) begin
                  level_next = sustain_level;
                  state_next = SUSTAIN;
               end else begin
                  level_next = env_level - decay_step;
               end
            end
            SUSTAIN: begin
               level_next = sustain_level;
            end
            RELEASE: begin
               if (release_done) begin
                  level_next = '0;
                  state_next = IDLE;
               end else begin
                  level_next = env_level - release_step;
               end
            end
            default: begin
               level_next = '0;
               state_next = IDLE;
            end
         endcase
      end
   end

   // Sign-extended sample times zero-extended level; low bits of the product are exact.
   assign sample_ext = {{(ENV_WIDTH + 1){sample_in[SAMPLE_WIDTH-1]}}, sample_in};
   assign env_ext    = {{(SAMPLE_WIDTH + 1){1'b0}}, env_level};
   assign product    = sample_ext * env_ext;
   assign unused_product_bits = ^{product[PROD_WIDTH-1], product[ENV_WIDTH-1:0]};

   always_ff @(posedge sample_clock or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         env_level  <= '0;
         gate_q     <= 1'b0;
         out_sample <= '0;
      end else begin
         state      <= state_next;
         env_level  <= level_next;
         gate_q     <= gate;
         out_sample <= product[ENV_WIDTH +: SAMPLE_WIDTH];
      end
   end

   assign env_state = state;
   assign active    = (state != IDLE);

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator: driver queues expected results, monitor checks each edge.
module tb_envelope_generator;

   localparam logic [2:0] S_IDLE = 3'd0, S_ATT = 3'd1, S_DEC = 3'd2, S_SUS = 3'd3, S_REL = 3'd4;

   logic        sample_clock = 1'b0;
   logic        rst = 1'b0;
   logic        gate = 1'b0;
   logic [15:0] attack_step = '0;
   logic [15:0] decay_step = '0;
   logic [15:0] sustain_level = '0;
   logic [15:0] release_step = '0;
   logic [23:0] sample_in = '0;
   logic [23:0] out_sample;
   logic [15:0] env_level;
   logic [2:0]  env_state;
   logic        active;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] lvl;
      logic [2:0]  st;
      logic [23:0] o;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] prev_lvl = '0;

   envelope_generator #(.SAMPLE_WIDTH(24), .ENV_WIDTH(16)) dut (
      .sample_clock (sample_clock),
      .rst          (rst),
      .gate         (gate),
      .attack_step  (attack_step),
      .decay_step   (decay_step),
      .sustain_level(sustain_level),
      .release_step (release_step),
      .sample_in    (sample_in),
      .out_sample   (out_sample),
      .env_level    (env_level),
      .env_state    (env_state),
      .active       (active)
   );

   always #5 sample_clock = ~sample_clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // Drive one cycle at the falling edge and queue what the next rising edge must produce.
   task automatic cyc(input logic g, input logic [23:0] s, input logic [15:0] lvl,
                      input logic [2:0] st, input bit use_o = 1'b0, input logic [23:0] o = '0);
      exp_t   e;
      longint a;
      longint p;
      gate      = g;
      sample_in = s;
      a = $signed(s);
      p = a * longint'(prev_lvl);
      p = p >>> 16;
      e.lvl = lvl;
      e.st  = st;
      e.o   = use_o ? o : p[23:0];
      exp_q.push_back(e);
      prev_lvl = lvl;
      @(negedge sample_clock);
   endtask

   always @(posedge sample_clock) begin
      #1;
      if (!rst && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("env_level", 32'(env_level), 32'(e.lvl));
         chk("env_state", 32'(env_state), 32'(e.st));
         chk("active", 32'(active), 32'(e.st != S_IDLE));
         chk("out_sample", 32'(out_sample), 32'(e.o));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      sample_in = 24'h400000;
      #1 rst = 1'b1;
      #1;
      chk("reset_level", 32'(env_level), 32'h0);
      chk("reset_state", 32'(env_state), 32'h0);
      chk("reset_active", 32'(active), 32'h0);
      chk("reset_out", 32'(out_sample), 32'h0);
      @(negedge sample_clock);
      rst = 1'b0;

      // 1: idle with gate low
      for (int i = 0; i < 5; i++) cyc(1'b0, 24'h400000, 16'h0000, S_IDLE, 1'b1, 24'h0);

      // 2: attack then decay into sustain
      attack_step   = 16'h4000;
      decay_step    = 16'h1000;
      sustain_level = 16'h8000;
      release_step  = 16'h2000;
      cyc(1'b1, 24'h400000, 16'h4000, S_ATT);
      cyc(1'b1, 24'h400000, 16'h8000, S_ATT);
      cyc(1'b1, 24'h400000, 16'hC000, S_ATT);
      cyc(1'b1, 24'h400000, 16'hFFFF, S_DEC);
      for (int i = 1; i <= 7; i++) cyc(1'b1, 24'h400000, 16'(16'hFFFF - 16'h1000 * i), S_DEC);
      cyc(1'b1, 24'h400000, 16'h8000, S_SUS);
      cyc(1'b1, 24'h400000, 16'h8000, S_SUS);

      // 3: release to idle
      cyc(1'b0, 24'h400000, 16'h6000, S_REL);
      cyc(1'b0, 24'h400000, 16'h4000, S_REL);
      cyc(1'b0, 24'h400000, 16'h2000, S_REL);
      cyc(1'b0, 24'h400000, 16'h0000, S_IDLE);
      cyc(1'b0, 24'h400000, 16'h0000, S_IDLE, 1'b1, 24'h0);

      // 4: shaping at full scale, most-negative input, and zero level
      attack_step   = 16'h0000;
      decay_step    = 16'h0000;
      sustain_level = 16'hFFFF;
      release_step  = 16'h0000;
      cyc(1'b1, 24'h400000, 16'hFFFF, S_DEC, 1'b1, 24'h000000);
      cyc(1'b1, 24'h400000, 16'hFFFF, S_SUS, 1'b1, 24'h3FFFC0);
      cyc(1'b1, 24'h800000, 16'hFFFF, S_SUS, 1'b1, 24'h800080);
      cyc(1'b0, 24'h800000, 16'h0000, S_IDLE, 1'b1, 24'h800080);
      cyc(1'b0, 24'h800000, 16'h0000, S_IDLE, 1'b1, 24'h000000);

      // 5: retrigger from release keeps the level; one-cycle gate dip
      attack_step   = 16'h4000;
      decay_step    = 16'h0000;
      sustain_level = 16'h8000;
      release_step  = 16'h2000;
      cyc(1'b1, 24'h123456, 16'h4000, S_ATT);
      cyc(1'b1, 24'hF00000, 16'h8000, S_ATT);
      cyc(1'b1, 24'h7FFFFF, 16'hC000, S_ATT);
      cyc(1'b1, 24'h000001, 16'hFFFF, S_DEC);
      cyc(1'b1, 24'hFFFFFF, 16'h8000, S_SUS);
      cyc(1'b0, 24'h400000, 16'h6000, S_REL);
      cyc(1'b1, 24'h400000, 16'hA000, S_ATT, 1'b1, 24'h180000);
      cyc(1'b0, 24'h400000, 16'h8000, S_REL, 1'b1, 24'h280000);
      cyc(1'b1, 24'hC00000, 16'hC000, S_ATT, 1'b1, 24'hE00000);
      cyc(1'b1, 24'h400000, 16'hFFFF, S_DEC);
      cyc(1'b1, 24'h400000, 16'h8000, S_SUS);

      // 6: zero steps, live sustain, async reset mid-attack
      attack_step  = 16'h0000;
      release_step = 16'h0000;
      cyc(1'b0, 24'h400000, 16'h0000, S_IDLE);
      cyc(1'b1, 24'h400000, 16'hFFFF, S_DEC);
      cyc(1'b1, 24'h400000, 16'h8000, S_SUS);
      sustain_level = 16'h1234;
      cyc(1'b1, 24'h400000, 16'h1234, S_SUS);
      attack_step = 16'h0100;
      cyc(1'b0, 24'h400000, 16'h0000, S_IDLE);
      cyc(1'b1, 24'h400000, 16'h0100, S_ATT);
      cyc(1'b1, 24'h400000, 16'h0200, S_ATT);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_level", 32'(env_level), 32'h0);
      chk("async_rst_state", 32'(env_state), 32'h0);
      chk("async_rst_active", 32'(active), 32'h0);
      chk("async_rst_out", 32'(out_sample), 32'h0);
      prev_lvl = '0;
      @(negedge sample_clock);
      rst = 1'b0;
      // gate still high out of reset acts as a rise
      cyc(1'b1, 24'h400000, 16'h0100, S_ATT);
      cyc(1'b1, 24'h400000, 16'h0200, S_ATT);

      @(negedge sample_clock);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
ADSR envelope generator and amplitude shaper: the synthesis-side counterpart to the envelope analyzer. It produces an envelope level in response to a gate and applies it to the sample stream at one sample per sample_clock cycle (96 kHz). It sits in the audio path ahead of the output stage. The same stream can be fed to the analyzer for loopback checks.

Parameters:
SAMPLE_WIDTH, 24, width of sample_in/out_sample, signed two's complement
ENV_WIDTH, 16, width of envelope level/steps, unsigned; MAX = 2^ENV_WIDTH-1

Ports:
sample_clock  in  1  sample-rate clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
gate  in  1  note on (1) / off (0), sampled each edge
attack_step  in  ENV_WIDTH  level increment per cycle in ATTACK; 0 = instant
decay_step  in  ENV_WIDTH  level decrement per cycle in DECAY; 0 = instant
sustain_level  in  ENV_WIDTH  SUSTAIN target, read live
release_step  in  ENV_WIDTH  level decrement per cycle in RELEASE; 0 = instant
sample_in  in  SAMPLE_WIDTH  input sample, signed
out_sample  out  SAMPLE_WIDTH  shaped sample, signed, registered
env_level  out  ENV_WIDTH  current envelope level, registered
env_state  out  3  IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
active  out  1  env_state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (sample_clock, rst). On rst: env_state=IDLE, env_level=0, out_sample=0, active=0, gate_q=0. Reset mid-note clears immediately; there is no release tail.
- Edges: gate_q is gate registered. rise = gate & ~gate_q; fall = ~gate & gate_q. Edges act at the same edge that updates gate_q.
- Gate high when rst deasserts: counts as a rise on the first edge.
- Transition rules, evaluated each edge, first match wins:
  1. rise (from IDLE or RELEASE): state ATTACK. Apply the attack rule to the current level in the same edge. Retrigger from RELEASE does not zero the level.
  2. fall in ATTACK/DECAY/SUSTAIN: state RELEASE. Apply the release rule to the current level in the same edge.
  3. Otherwise, per state:
     - IDLE: level held 0.
     - ATTACK: if attack_step==0 or level >= MAX-attack_step, then level=MAX and state DECAY. Else level += attack_step.
     - DECAY: if decay_step==0 or level <= sustain_level+decay_step (compute at ENV_WIDTH+1 bits), then level=sustain_level and state SUSTAIN. Else level -= decay_step. This also covers sustain_level raised above level mid-decay: clamp to sustain_level and enter SUSTAIN.
     - SUSTAIN: level=sustain_level every cycle (tracks live changes).
     - RELEASE: if release_step==0 or level <= release_step, then level=0 and state IDLE. Else level -= release_step.
- Saturation: level never wraps; all compares are made without overflow.
- Shaping: out_sample(n+1) = (sample_in(n) * env_level(n)) >>> ENV_WIDTH.
  - Signed × zero-extended unsigned product, SAMPLE_WIDTH+ENV_WIDTH+1 bits, arithmetic shift (floor), truncated to SAMPLE_WIDTH.
  - env_level < 2^ENV_WIDTH, so the result never overflows.
  - Latency is 1 cycle, using env_level as registered before the edge.
- active and env_state are derived from the state register; no extra latency.

Test Plan:
1. Reset with gate=0, sample_in=0x400000, then run 5 cycles -> env_level=0, env_state=0, out_sample=0, active=0 throughout.
2. attack_step=0x4000, decay_step=0x1000, sustain_level=0x8000; raise gate -> env_level per edge 0x4000, 0x8000, 0xC000, 0xFFFF (state DECAY). Then 0xEFFF … 0x8FFF over 7 edges, then 0x8000 with state SUSTAIN on the 8th.
3. From SUSTAIN at 0x8000 with release_step=0x2000, drop gate -> 0x6000, 0x4000, 0x2000, then 0x0000 with state IDLE and active=0 on the 4th edge.
4. Shaping: env_level=0xFFFF with sample_in=0x400000 -> out_sample=0x3FFFC0 next cycle. sample_in=0x800000 -> out_sample=0x800080 (-8388480). env_level=0 -> 0.
5. Retrigger: in RELEASE at level 0x6000 with attack_step=0x4000, raise gate -> next edge level 0xA000, state ATTACK. Then pulse gate low one cycle -> RELEASE, then back to ATTACK on re-rise.
6. Zero steps and live sustain: all steps 0 -> gate rise gives 0xFFFF, then sustain_level on the next edge. Changing sustain_level to 0x1234 in SUSTAIN -> env_level=0x1234 next edge. Assert rst mid-ATTACK -> all outputs 0 immediately, without waiting for a clock edge.
